// File: rtl/reduce_result_collector_pkg.sv
// Shared stream constants for the reduce result collector.
// Holds the default widths, the window size and the control state encoding.
package reduce_result_collector_pkg;

    localparam int DATA_WIDTH_DEF  = 32;
    localparam int WINDOW_LOG2_DEF = 4;
    localparam int REDUCER_SIZE    = 1 << WINDOW_LOG2_DEF;
    localparam int FIFO_LOG2_DEF   = 2;
    localparam int COUNT_WIDTH_DEF = 32;

    localparam logic [0:0] ST_FLUSH = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

endpackage

// File: rtl/reduce_result_collector_sync_fifo_ptr.sv
// Single-clock FIFO with wrap-bit pointers, async reset and sync flush.
// The head entry is presented combinationally from the read pointer.
module sync_fifo_ptr #(
    parameter int WIDTH = 32,
    parameter int LOG2  = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic             o_full,
    output logic             o_empty,
    output logic [LOG2:0]    o_level,
    output logic [WIDTH-1:0] o_head
);

    localparam int          DEPTH   = 1 << LOG2;
    localparam logic [LOG2:0] PTR_ONE = {{LOG2{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [LOG2:0]    r_wr_ptr;
    logic [LOG2:0]    r_rd_ptr;
    logic [LOG2-1:0]  w_wr_idx;
    logic [LOG2-1:0]  w_rd_idx;

    assign w_wr_idx = r_wr_ptr[LOG2-1:0];
    assign w_rd_idx = r_rd_ptr[LOG2-1:0];

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (w_wr_idx == w_rd_idx) &&
                     (r_wr_ptr[LOG2] != r_rd_ptr[LOG2]);
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_head  = r_mem[w_rd_idx];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (i_rd_en) r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && !i_flush) r_mem[w_wr_idx] <= i_wr_data;
    end

endmodule

// File: rtl/reduce_result_collector.sv
// Captures pulsed window sums into a FIFO and serves sum and mean downstream.
// Also tracks accepted results and a sticky drop flag.
module reduce_result_collector
    import reduce_result_collector_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int WINDOW_LOG2 = WINDOW_LOG2_DEF,
    parameter int FIFO_LOG2   = FIFO_LOG2_DEF,
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic [DATA_WIDTH-1:0]  zdata,
    input  logic                   vdata,
    input  logic                   clear,
    output logic [DATA_WIDTH-1:0]  out_sum,
    output logic [DATA_WIDTH-1:0]  out_mean,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COUNT_WIDTH-1:0] result_count,
    output logic                   overflow,
    output logic [FIFO_LOG2:0]     level
);

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]                   r_state;
    logic [COUNT_WIDTH-1:0]       r_count;
    logic                         r_overflow;
    logic                         w_run;
    logic                         w_full;
    logic                         w_empty;
    logic                         w_rd;
    logic                         w_wr;
    logic                         w_drop;
    logic [DATA_WIDTH-1:0]        w_head;
    logic signed [DATA_WIDTH-1:0] w_mean;

    assign w_run     = (r_state == ST_RUN);
    assign out_valid = w_run && !w_empty;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign w_rd   = out_valid && out_ready && !clear;
    assign w_wr   = w_run && vdata && !clear && (!w_full || w_rd);
    assign w_drop = w_run && vdata && !clear && w_full && !w_rd;

    sync_fifo_ptr #(
        .WIDTH (DATA_WIDTH),
        .LOG2  (FIFO_LOG2)
    ) u_fifo (
        .i_clk     (CLK),
        .i_rst_n   (RSTN),
        .i_flush   (clear),
        .i_wr_en   (w_wr),
        .i_wr_data (zdata),
        .i_rd_en   (w_rd),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (level),
        .o_head    (w_head)
    );

    assign w_mean   = $signed(w_head) >>> WINDOW_LOG2;
    assign out_sum  = out_valid ? w_head : '0;
    assign out_mean = out_valid ? w_mean : '0;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ST_FLUSH;
        end else if (clear) begin
            r_state <= ST_FLUSH;
        end else begin
            r_state <= ST_RUN;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)   r_count    <= r_count + CNT_ONE;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    assign result_count = r_count;
    assign overflow     = r_overflow;

endmodule
